i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) endpoint that answers an external I2C controller on the board bus. SCL/SDA are oversampled on the 24 MHz system clock; the block detects START/STOP, matches a 7-bit address, and exchanges bytes with user logic. Received bytes go out on a strobe interface, and read bytes are requested on demand. It sits beside the clock block, on the opposite side of the I2C link from the FPGA's own controller logic.

## Interface
- `ADDRESS`, default 7'h50: 7-bit target address matched against the first byte after START.
- `clk`  in  1: 24 MHz system clock; all logic on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `scl_in`  in  1: raw SCL pin level, asynchronous.
- `sda_in`  in  1: raw SDA pin level, asynchronous.
- `sda_oe`  out  1: 1 pulls SDA low (open-drain); 0 releases it.
- `rx_data`  out  8: last byte written by the controller.
- `rx_valid`  out  1: one-cycle strobe when `rx_data` updates.
- `rx_first`  out  1: qualifies `rx_valid`; 1 for the first data byte after the address.
- `tx_req`  out  1: one-cycle strobe requesting the next read byte.
- `tx_data`  in  8: read byte; captured on the clk edge after `tx_req`.
- `busy`  out  1: 1 from an addressed START until STOP, NACK-end or mismatch.
- `stop`  out  1: one-cycle strobe on every detected STOP.

## Operation
- **Input conditioning**
  - 2-flop synchronizer on each input; sync flops reset to 1 (idle bus).
  - Edge detect compares the current and previous synchronized samples.
- **Bus conditions**
  - START: SDA falls while SCL is high in both samples.
  - STOP: SDA rises while SCL is high in both samples.
  - If SCL and SDA change in the same sample, neither START nor STOP is flagged.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- **Transitions**
  - START from any state → ADDR: bit counter cleared, `sda_oe`=0. This covers repeated START.
  - STOP from any state → IDLE: `sda_oe`=0, `busy`=0, `stop` pulses.
  - ADDR: shift SDA in on each SCL rise, MSB first. After 8 bits:
    - address match → ADDR_ACK;
    - mismatch → IGNORE, `busy`=0, `sda_oe` never asserted.
  - ADDR_ACK:
    - next SCL fall: `sda_oe`=1;
    - following SCL fall: `sda_oe`=0 (write) or drive tx bit 7 (read);
    - then → WRITE or READ.
  - R/W bit = 1: `tx_req` pulses on the 8th address-bit rise.
  - WRITE: shift 8 bits on SCL rises.
    - On the 8th rise: update `rx_data`, pulse `rx_valid`, set `rx_first`=1 only for the first byte after the address.
    - → WRITE_ACK: ACK on the next falling edge, release on the one after; every byte is ACKed.
  - READ:
    - each SCL fall: `sda_oe` = ~bit, MSB first;
    - after the 8th bit's falling edge: `sda_oe`=0 → READ_ACK.
  - READ_ACK: sample SDA on SCL rise.
    - low (ACK): pulse `tx_req`, → READ;
    - high (NACK): → IGNORE, `busy`=0.
  - IGNORE: wait for START or STOP.
- No clock stretching; no general-call support.
- **Reset values:** `sda_oe`=0, `rx_data`=0, `rx_valid`=0, `rx_first`=0, `tx_req`=0, `busy`=0, `stop`=0, state IDLE. Reset mid-transfer releases SDA immediately (asynchronously).

## Timing
- Pin edge → internal event: 3 clk (2 sync + 1 edge detect). The filter adds 2 clk.
- `sda_oe` changes 1 clk after the internal SCL-fall event.
- `rx_valid` is asserted 1 clk after the internal 8th SCL-rise event.
- `tx_data` must be stable on the clk edge after `tx_req`. Data is first driven at the next SCL fall, at least 4 clk later.
- Required SCL high/low time: ≥ 6 clk (≥ 8 clk with the filter). 400 kHz gives ~30 clk per phase.
- The bit counter wraps 7→0 at each byte boundary. There is no limit on transfer length.

## Configuration
- `I2C_TARGET_FILTER_EN` defined: a 3-sample majority filter follows each synchronizer. It rejects glitches of ≤ 1 clk and adds 2 clk latency.
- Undefined: synchronizer only. Glitches of 1 clk are passed through.

## Test plan
- Write 0xA0 0x12 0x34 then STOP at 400 kHz, ADDRESS=0x50:
  - ACK on the address and on both data bytes;
  - `rx_valid` ×2 with `rx_data` 0x12 (`rx_first`=1), then 0x34 (`rx_first`=0);
  - `stop` pulse.
- Read 0xA1 with `tx_data` 0x5A then 0xC3; controller ACK, NACK, STOP:
  - SDA sees 0x5A then 0xC3;
  - `tx_req` ×2;
  - `busy`=0 after the NACK.
- Address 0xA4 (mismatch): `sda_oe` stays 0 for the whole frame, no strobes, `stop` pulses.
- Write 0xA0 0x77, repeated START, read 0xA1:
  - `rx_valid` with 0x77, then `tx_req`;
  - `sda_oe`=0 on the repeated START.
- Assert `reset_n`=0 while `sda_oe`=1 during a read: `sda_oe`=0 with no clk edge; after release the block is in IDLE and ignores bus activity until START.
- With the filter on, inject a 1-clk SDA low pulse while SCL is high: no START detected and no state change.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target endpoint with 7-bit address match.
// Define I2C_TARGET_FILTER_EN to add a 3-sample majority glitch filter.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       stop
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_e;

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_c, sda_c;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;

    // Two-flop synchronizers; idle bus level is high
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d;
    logic       sda_filt_q, sda_filt_d;

    function automatic logic maj3(input logic a, input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over three samples rejects single-clk glitches
    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_filt_d = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end

    // Filter history and registered vote
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_c = scl_filt_q;
    assign sda_c = sda_filt_q;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    // Previous conditioned sample for edge detection
    always_comb begin
        scl_prev_d = scl_c;
        sda_prev_d = sda_c;
    end

    // Edge-detect history flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    assign bus_start = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign bus_stop  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       first_q, first_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;

    logic       last_bit, addr_hit;
    logic [7:0] byte_in;
    assign last_bit = (bit_cnt_q == 3'd7);
    assign addr_hit = (shift_q == ADDRESS);
    assign byte_in  = {shift_q, sda_c};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            tx_shift_q <= 8'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
        end
    end

    // Next state: bus conditions override all protocol progress
    always_comb begin
        state_d = state_q;
        if (bus_stop) begin
            state_d = ST_IDLE;
        end else if (bus_start) begin
            state_d = ST_ADDR;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise && last_bit)
                        state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && phase_q)
                        state_d = rw_q ? ST_READ : ST_WRITE;
                end
                ST_WRITE: begin
                    if (scl_rise && last_bit)
                        state_d = ST_WRITE_ACK;
                end
                ST_WRITE_ACK: begin
                    if (scl_fall && phase_q)
                        state_d = ST_WRITE;
                end
                ST_READ: begin
                    if (scl_fall && phase_q)
                        state_d = ST_READ_ACK;
                end
                ST_READ_ACK: begin
                    if (scl_rise)
                        state_d = sda_c ? ST_IGNORE : ST_READ;
                end
                default: ;
            endcase
        end
    end

    // Outputs and datapath; phase_q marks the second half of an ACK slot
    // or, in READ, that all 8 bits are already on the wire
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_req_q ? tx_data : tx_shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        first_d    = first_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = rx_first_q;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        stop_d     = 1'b0;
        if (bus_stop) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b1;
        end else if (bus_start) begin
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b0;
                            if (addr_hit) begin
                                busy_d   = 1'b1;
                                rw_d     = sda_c;
                                tx_req_d = sda_c;
                            end else begin
                                busy_d = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q) begin
                                sda_oe_d  = ~tx_shift_q[7];
                                bit_cnt_d = 3'd1;
                            end else begin
                                sda_oe_d = 1'b0;
                                first_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            phase_d    = 1'b0;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~phase_q;
                        phase_d  = ~phase_q;
                    end
                end
                ST_READ: begin
                    if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                        end else begin
                            sda_oe_d  = ~tx_shift_q[~bit_cnt_q];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            phase_d   = last_bit;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_c)
                            tx_req_d = 1'b1;
                        else
                            busy_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign stop     = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller driving i2c_target,
// checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h50;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_req;
    logic [7:0] tx_data = 8'h00;
    logic       busy;
    logic       stop;

    int checks = 0;
    int errors = 0;

    // open-drain bus: either side may pull SDA low
    assign sda_in = sda_drv & ~sda_oe;

    i2c_target #(.ADDRESS(ADDR)) dut (
        .clk(clk), .reset_n(reset_n),
        .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .tx_req(tx_req), .tx_data(tx_data),
        .busy(busy), .stop(stop)
    );

    always #5 clk = ~clk;

    logic [8:0] rx_log [256];
    int         rx_n = 0;
    int         n_stop = 0;
    int         n_oe = 0;
    logic [7:0] tx_buf [64];
    int         tx_wr = 0;
    int         tx_rd = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_n < 256) begin
            rx_log[rx_n] = {rx_first, rx_data};
            rx_n++;
        end
        if (stop) n_stop++;
        if (sda_oe) n_oe++;
        if (tx_req) begin
            tx_data = (tx_rd < tx_wr) ? tx_buf[tx_rd] : 8'hFF;
            tx_rd++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_buf[tx_wr] = d;
        tx_wr++;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl_in = 1'b1;  wait_clk(2*Q);
        sda_drv = 1'b0; wait_clk(2*Q);
        scl_in = 1'b0;  wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_in = 1'b1;  wait_clk(2*Q);
        sda_drv = 1'b1; wait_clk(2*Q);
    endtask

    task automatic send_bit(input logic b, output logic line);
        sda_drv = b;   wait_clk(Q);
        scl_in = 1'b1; wait_clk(Q);
        line = sda_in; wait_clk(Q);
        scl_in = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) send_bit(d[i], l);
        send_bit(1'b1, l);
        ack = ~l;
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l);
            d[i] = l;
        end
        send_bit(~ack_it, l);
    endtask

    task automatic test_reset();
        wait_clk(3);
        if (sda_oe !== 1'b0) begin errors++;
            $display("FAIL rst_oe got %b want 0", sda_oe); end
        checks++;
        if (rx_data !== 8'h00) begin errors++;
            $display("FAIL rst_rxd got %h want 00", rx_data); end
        checks++;
        if ({rx_valid, rx_first, tx_req, busy, stop} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 00000",
                     {rx_valid, rx_first, tx_req, busy, stop});
        end
        checks++;
        reset_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_write();
        int r0 = rx_n, s0 = n_stop;
        logic a;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA0; bytes[1] = 8'h12; bytes[2] = 8'h34;
        bus_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], a);
            if (a !== 1'b1) begin errors++;
                $display("FAIL wr_ack%0d got %b want 1", i, a); end
            checks++;
        end
        bus_stop();
        wait_clk(5);
        if (rx_n - r0 !== 2) begin errors++;
            $display("FAIL wr_count got %0d want 2", rx_n - r0); end
        checks++;
        if (rx_log[r0] !== 9'h112) begin errors++;
            $display("FAIL wr_b0 got %h want 112", rx_log[r0]); end
        checks++;
        if (rx_log[r0+1] !== 9'h034) begin errors++;
            $display("FAIL wr_b1 got %h want 034", rx_log[r0+1]); end
        checks++;
        if (n_stop - s0 !== 1) begin errors++;
            $display("FAIL wr_stop got %0d want 1", n_stop - s0); end
        checks++;
    endtask

    task automatic test_read();
        int t0 = tx_rd, s0 = n_stop;
        logic a;
        logic [7:0] d;
        push_tx(8'h5A); push_tx(8'hC3);
        bus_start();
        send_byte(8'hA1, a);
        if (a !== 1'b1) begin errors++;
            $display("FAIL rd_ack got %b want 1", a); end
        checks++;
        if (busy !== 1'b1) begin errors++;
            $display("FAIL rd_busy got %b want 1", busy); end
        checks++;
        recv_byte(1'b1, d);
        if (d !== 8'h5A) begin errors++;
            $display("FAIL rd_b0 got %h want 5a", d); end
        checks++;
        recv_byte(1'b0, d);
        if (d !== 8'hC3) begin errors++;
            $display("FAIL rd_b1 got %h want c3", d); end
        checks++;
        wait_clk(4);
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rd_nack_busy got %b want 0", busy); end
        checks++;
        bus_stop();
        wait_clk(5);
        if (tx_rd - t0 !== 2) begin errors++;
            $display("FAIL rd_txreq got %0d want 2", tx_rd - t0); end
        checks++;
        if (n_stop - s0 !== 1) begin errors++;
            $display("FAIL rd_stop got %0d want 1", n_stop - s0); end
        checks++;
    endtask

    task automatic test_mismatch();
        int r0 = rx_n, s0 = n_stop, o0 = n_oe, t0 = tx_rd;
        logic a;
        bus_start();
        send_byte(8'hA4, a);
        send_byte(8'h55, a);
        bus_stop();
        wait_clk(5);
        if (n_oe - o0 !== 0) begin errors++;
            $display("FAIL mm_oe got %0d want 0", n_oe - o0); end
        checks++;
        if ((rx_n - r0) + (tx_rd - t0) !== 0) begin errors++;
            $display("FAIL mm_strobes got %0d want 0",
                     (rx_n - r0) + (tx_rd - t0)); end
        checks++;
        if (n_stop - s0 !== 1) begin errors++;
            $display("FAIL mm_stop got %0d want 1", n_stop - s0); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int r0 = rx_n, t0 = tx_rd;
        logic a;
        logic [7:0] d;
        push_tx(8'h9C);
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h77, a);
        bus_start();
        if (sda_oe !== 1'b0) begin errors++;
            $display("FAIL rs_oe got %b want 0", sda_oe); end
        checks++;
        send_byte(8'hA1, a);
        if (a !== 1'b1) begin errors++;
            $display("FAIL rs_ack got %b want 1", a); end
        checks++;
        recv_byte(1'b0, d);
        if (d !== 8'h9C) begin errors++;
            $display("FAIL rs_rd got %h want 9c", d); end
        checks++;
        bus_stop();
        wait_clk(5);
        if (rx_n - r0 !== 1 || rx_log[r0] !== 9'h177) begin errors++;
            $display("FAIL rs_wr got %0d/%h want 1/177",
                     rx_n - r0, rx_log[r0]); end
        checks++;
        if (tx_rd - t0 !== 1) begin errors++;
            $display("FAIL rs_txreq got %0d want 1", tx_rd - t0); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int r0, t0, o0;
        logic a, l;
        push_tx(8'h00);
        bus_start();
        send_byte(8'hA1, a);
        sda_drv = 1'b1; wait_clk(Q);
        scl_in = 1'b1;  wait_clk(Q);
        if (sda_oe !== 1'b1) begin errors++;
            $display("FAIL rm_pre got %b want 1", sda_oe); end
        checks++;
        #2;
        reset_n = 1'b0;
        #1;
        if (sda_oe !== 1'b0) begin errors++;
            $display("FAIL rm_async got %b want 0", sda_oe); end
        checks++;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(3);
        r0 = rx_n; t0 = tx_rd; o0 = n_oe;
        scl_in = 1'b0; wait_clk(Q);
        for (int i = 0; i < 18; i++)
            send_bit(1'($urandom_range(0, 1)), l);
        if (n_oe - o0 !== 0 || busy !== 1'b0) begin errors++;
            $display("FAIL rm_idle got oe=%0d busy=%b want 0/0",
                     n_oe - o0, busy); end
        checks++;
        if ((rx_n - r0) + (tx_rd - t0) !== 0) begin errors++;
            $display("FAIL rm_strobes got %0d want 0",
                     (rx_n - r0) + (tx_rd - t0)); end
        checks++;
        bus_stop();
        bus_start();
        send_byte(8'hA0, a);
        if (a !== 1'b1) begin errors++;
            $display("FAIL rm_after got %b want 1", a); end
        checks++;
        send_byte(8'h3C, a);
        bus_stop();
        wait_clk(5);
        if (rx_log[rx_n-1] !== 9'h13C) begin errors++;
            $display("FAIL rm_rx got %h want 13c", rx_log[rx_n-1]); end
        checks++;
    endtask

    task automatic test_random_write();
        logic [8:0] exp_q [$];
        logic [6:0] ad;
        logic [7:0] d;
        logic a, match;
        int n, r0;
        for (int k = 0; k < 6; k++) begin
            ad = ($urandom_range(0, 1) == 1) ? ADDR
                                             : 7'($urandom_range(0, 127));
            match = (ad == ADDR);
            n = $urandom_range(1, 3);
            r0 = rx_n;
            exp_q.delete();
            bus_start();
            send_byte({ad, 1'b0}, a);
            if (a !== match) begin errors++;
                $display("FAIL rw_addr %h got %b want %b", ad, a, match); end
            checks++;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                send_byte(d, a);
                if (a !== match) begin errors++;
                    $display("FAIL rw_dack got %b want %b", a, match); end
                checks++;
                if (match) exp_q.push_back({(i == 0), d});
            end
            bus_stop();
            wait_clk(5);
            if (rx_n - r0 !== exp_q.size()) begin errors++;
                $display("FAIL rw_count got %0d want %0d",
                         rx_n - r0, exp_q.size()); end
            checks++;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (rx_log[r0+i] !== exp_q[i]) begin errors++;
                    $display("FAIL rw_data got %h want %h",
                             rx_log[r0+i], exp_q[i]); end
                checks++;
            end
        end
    endtask

    task automatic test_random_read();
        logic [7:0] exp_q [$];
        logic [7:0] d;
        logic a;
        int n, t0;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 3);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                exp_q.push_back(d);
                push_tx(d);
            end
            t0 = tx_rd;
            bus_start();
            send_byte({ADDR, 1'b1}, a);
            if (a !== 1'b1) begin errors++;
                $display("FAIL rr_ack got %b want 1", a); end
            checks++;
            for (int i = 0; i < n; i++) begin
                recv_byte(i < n - 1, d);
                if (d !== exp_q[i]) begin errors++;
                    $display("FAIL rr_data got %h want %h", d, exp_q[i]); end
                checks++;
            end
            wait_clk(4);
            if (busy !== 1'b0) begin errors++;
                $display("FAIL rr_busy got %b want 0", busy); end
            checks++;
            bus_stop();
            wait_clk(5);
            if (tx_rd - t0 !== n) begin errors++;
                $display("FAIL rr_txreq got %0d want %0d", tx_rd - t0, n); end
            checks++;
        end
    endtask

`ifdef I2C_TARGET_FILTER_EN
    task automatic test_glitch();
        int o0 = n_oe, s0 = n_stop;
        logic a;
        @(negedge clk);
        sda_drv = 1'b0;
        @(negedge clk);
        sda_drv = 1'b1;
        wait_clk(10);
        scl_in = 1'b0; wait_clk(Q);
        send_byte(8'hA0, a);
        if (n_oe - o0 !== 0 || busy !== 1'b0) begin errors++;
            $display("FAIL gl_nostart got oe=%0d busy=%b want 0/0",
                     n_oe - o0, busy); end
        checks++;
        bus_stop();
        wait_clk(5);
        if (n_stop - s0 !== 1) begin errors++;
            $display("FAIL gl_stop got %0d want 1", n_stop - s0); end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        test_random_write();
        test_random_read();
`ifdef I2C_TARGET_FILTER_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
